// File: rtl/tree_pkg.sv
// Tree-image definitions shared by the walker and the tree generator:
// node word layout, command opcodes and node field slice helpers.
package tree_pkg;

  localparam int ID_W      = 8;
  localparam int ADDR_W    = 8;
  localparam int MAX_CHILD = 4;
  localparam int MAX_DEPTH = 4;
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);
  localparam int SLOT_W    = $clog2(MAX_CHILD);
  // Node word: {parent, child[MAX_CHILD-1] .. child[0], id}
  localparam int NODE_W    = ID_W + ADDR_W * (MAX_CHILD + 1);

  typedef enum logic [1:0] {
    OP_DESCEND = 2'd0,
    OP_ASCEND  = 2'd1,
    OP_ROOT    = 2'd2
  } tree_op_e;

  function automatic logic [ADDR_W-1:0] node_child(input logic [NODE_W-1:0] node,
                                                   input logic [SLOT_W-1:0] k);
    return node[ID_W + int'(k) * ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] node_parent(input logic [NODE_W-1:0] node);
    return node[NODE_W-1 -: ADDR_W];
  endfunction

  function automatic logic [ID_W-1:0] node_id(input logic [NODE_W-1:0] node);
    return node[ID_W-1:0];
  endfunction

  // The reserved opcode behaves as ROOT.
  function automatic tree_op_e decode_op(input logic [1:0] op);
    case (op)
      2'd0:    return OP_DESCEND;
      2'd1:    return OP_ASCEND;
      default: return OP_ROOT;
    endcase
  endfunction

endpackage

// File: rtl/tree_walk_ctrl.sv
// Walks the tree image in a single-read-port node RAM: DESCEND/ASCEND/ROOT
// commands, one child slot probed per read, one response per command.
//
// state   | meaning
// INIT_RD | issue the read of the root word (addr 0)
// INIT_LD | capture root word, enter IDLE
// IDLE    | cmd_ready high, accept and classify a command
// RD      | read strobe cycle for the current slot / parent / root
// CMP     | node word valid: compare id or load node
// RESP    | response held until rsp_ready
module tree_walk_ctrl
  import tree_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ID_W-1:0]   cmd_id,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_found,
  output logic [ADDR_W-1:0] rsp_node_addr,
  output logic [ID_W-1:0]   rsp_node_id,
  output logic [DEPTH_W-1:0] rsp_depth,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [NODE_W-1:0] mem_rd_data
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(MAX_CHILD - 1);

  typedef enum logic [2:0] {
    ST_INIT_RD,
    ST_INIT_LD,
    ST_IDLE,
    ST_RD,
    ST_CMP,
    ST_RESP
  } state_e;

  state_e              r_state;
  tree_op_e            r_op;
  logic [ID_W-1:0]     r_id;
  logic [SLOT_W-1:0]   r_slot;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [NODE_W-1:0]   r_cur_node;
  logic [DEPTH_W-1:0]  r_depth;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic                r_rsp_found;
  logic                r_mem_rd_en;
  logic [ADDR_W-1:0]   r_mem_rd_addr;

  tree_op_e            w_op;
  logic [SLOT_W-1:0]   w_slot_nxt;
  logic [ADDR_W-1:0]   w_cur_child;
  logic [ADDR_W-1:0]   w_first_child;
  logic [ADDR_W-1:0]   w_next_child;
  logic                w_match;

  assign w_op          = decode_op(cmd_op);
  assign w_slot_nxt    = r_slot + 1'b1;
  assign w_cur_child   = node_child(r_cur_node, r_slot);
  assign w_first_child = node_child(r_cur_node, '0);
  assign w_next_child  = node_child(r_cur_node, w_slot_nxt);
  // An id of 0 is never a valid search key, so it can never hit.
  assign w_match       = (node_id(mem_rd_data) == r_id) && (r_id != '0);

  // The read strobe is registered on entry to RD so it is high exactly in RD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_INIT_RD;
      r_op          <= OP_ROOT;
      r_id          <= '0;
      r_slot        <= '0;
      r_cur_addr    <= '0;
      r_cur_node    <= '0;
      r_depth       <= '0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_found   <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
    end else begin
      case (r_state)
        ST_INIT_RD: begin
          if (!r_mem_rd_en) begin
            r_mem_rd_en   <= 1'b1;
            r_mem_rd_addr <= '0;
          end else begin
            r_mem_rd_en <= 1'b0;
            r_state     <= ST_INIT_LD;
          end
        end
        ST_INIT_LD: begin
          r_cur_node  <= mem_rd_data;
          r_cur_addr  <= '0;
          r_depth     <= '0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_op        <= w_op;
            r_id        <= cmd_id;
            r_slot      <= '0;
            case (w_op)
              OP_DESCEND: begin
                if (r_depth == DEPTH_MAX) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_found <= 1'b0;
                  r_state     <= ST_RESP;
                end else begin
                  r_mem_rd_en   <= (w_first_child != '0);
                  r_mem_rd_addr <= w_first_child;
                  r_state       <= ST_RD;
                end
              end
              OP_ASCEND: begin
                if (r_depth == '0) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_found <= 1'b0;
                  r_state     <= ST_RESP;
                end else begin
                  r_mem_rd_en   <= 1'b1;
                  r_mem_rd_addr <= node_parent(r_cur_node);
                  r_state       <= ST_RD;
                end
              end
              default: begin
                r_mem_rd_en   <= 1'b1;
                r_mem_rd_addr <= '0;
                r_state       <= ST_RD;
              end
            endcase
          end
        end
        ST_RD: begin
          r_mem_rd_en <= 1'b0;
          if ((r_op == OP_DESCEND) && (w_cur_child == '0)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_found <= 1'b0;
            r_state     <= ST_RESP;
          end else begin
            r_state <= ST_CMP;
          end
        end
        ST_CMP: begin
          case (r_op)
            OP_DESCEND: begin
              if (w_match) begin
                r_cur_node  <= mem_rd_data;
                r_cur_addr  <= w_cur_child;
                r_depth     <= r_depth + 1'b1;
                r_rsp_valid <= 1'b1;
                r_rsp_found <= 1'b1;
                r_state     <= ST_RESP;
              end else if (r_slot == SLOT_LAST) begin
                r_rsp_valid <= 1'b1;
                r_rsp_found <= 1'b0;
                r_state     <= ST_RESP;
              end else begin
                r_slot        <= w_slot_nxt;
                r_mem_rd_en   <= (w_next_child != '0);
                r_mem_rd_addr <= w_next_child;
                r_state       <= ST_RD;
              end
            end
            OP_ASCEND: begin
              r_cur_node  <= mem_rd_data;
              r_cur_addr  <= node_parent(r_cur_node);
              r_depth     <= r_depth - 1'b1;
              r_rsp_valid <= 1'b1;
              r_rsp_found <= 1'b1;
              r_state     <= ST_RESP;
            end
            default: begin
              r_cur_node  <= mem_rd_data;
              r_cur_addr  <= '0;
              r_depth     <= '0;
              r_rsp_valid <= 1'b1;
              r_rsp_found <= 1'b1;
              r_state     <= ST_RESP;
            end
          endcase
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_INIT_RD;
      endcase
    end
  end

  // Position outputs come straight from the position registers, which only
  // change on the cycle a response is raised, so they hold through RESP.
  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_found     = r_rsp_found;
  assign rsp_node_addr = r_cur_addr;
  assign rsp_node_id   = node_id(r_cur_node);
  assign rsp_depth     = r_depth;
  assign mem_rd_en     = r_mem_rd_en;
  assign mem_rd_addr   = r_mem_rd_addr;

endmodule

// File: tb/tb_tree_walk_ctrl.sv
// Scoreboard bench for tree_walk_ctrl: a tree-level reference model predicts each
// response; a monitor pops and compares whenever rsp_valid is presented.
module tb_tree_walk_ctrl;
  import tree_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [ID_W-1:0]    cmd_id;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_found;
  logic [ADDR_W-1:0]  rsp_node_addr;
  logic [ID_W-1:0]    rsp_node_id;
  logic [DEPTH_W-1:0] rsp_depth;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic [NODE_W-1:0]  mem_rd_data;

  tree_walk_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_id        (cmd_id),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_found     (rsp_found),
    .rsp_node_addr (rsp_node_addr),
    .rsp_node_id   (rsp_node_id),
    .rsp_depth     (rsp_depth),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Node RAM: data appears the cycle after the strobe; junk otherwise.
  logic [NODE_W-1:0] mem [0:255];
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : NODE_W'({$urandom, $urandom});

  typedef struct {
    logic               found;
    logic [ADDR_W-1:0]  addr;
    logic [ID_W-1:0]    id;
    logic [DEPTH_W-1:0] depth;
    int                 lat;
    int                 reads;
    int                 t_acc;
    int                 rd0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   rd_total = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0;
  int   hold_req = 0;
  bit   rand_bp = 0;
  bit   in_rsp = 0;
  int   m_cur = 0;
  int   m_depth = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [NODE_W-1:0] mk_node(input int id, input int c0, input int c1,
                                                input int c2, input int c3, input int p);
    return {ADDR_W'(p), ADDR_W'(c3), ADDR_W'(c2), ADDR_W'(c1), ADDR_W'(c0), ID_W'(id)};
  endfunction

  // Reference: search children in order, stop at an empty slot, hit on first id match.
  task automatic model(input logic [1:0] op, input logic [ID_W-1:0] id, output exp_t e);
    logic [NODE_W-1:0] w;
    logic [NODE_W-1:0] cw;
    int c;
    e.found = 1'b0;
    e.reads = 0;
    e.lat   = 1;
    w = mem[m_cur];
    if (op == 2'd0) begin
      if (m_depth != MAX_DEPTH) begin
        e.lat = 1 + 2 * MAX_CHILD;
        for (int k = 0; k < MAX_CHILD; k++) begin
          c = int'(w[ID_W + k * ADDR_W +: ADDR_W]);
          if (c == 0) begin
            e.lat = 2 + 2 * k;
            break;
          end
          e.reads++;
          cw = mem[c];
          if (id != 0 && cw[ID_W-1:0] == id) begin
            e.found = 1'b1;
            e.lat   = 3 + 2 * k;
            m_cur   = c;
            m_depth++;
            break;
          end
        end
      end
    end else if (op == 2'd1) begin
      if (m_depth != 0) begin
        m_cur   = int'(w[NODE_W-1 -: ADDR_W]);
        m_depth--;
        e.found = 1'b1;
        e.lat   = 3;
        e.reads = 1;
      end
    end else begin
      m_cur   = 0;
      m_depth = 0;
      e.found = 1'b1;
      e.lat   = 3;
      e.reads = 1;
    end
    w       = mem[m_cur];
    e.addr  = ADDR_W'(m_cur);
    e.id    = w[ID_W-1:0];
    e.depth = DEPTH_W'(m_depth);
  endtask

  task automatic send(input logic [1:0] op, input logic [ID_W-1:0] id);
    exp_t e;
    int n;
    model(op, id, e);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_id    = id;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    e.t_acc = cyc;
    e.rd0   = rd_total;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || in_rsp || rsp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("rsp_timeout", 0, 1);
  endtask

  // Called on a falling edge; holds rst for three cycles then checks the init sequence.
  task automatic do_reset();
    int t0, r0, n;
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {cmd_ready, rsp_valid, rsp_found, rsp_node_addr, rsp_node_id,
                        rsp_depth, mem_rd_en, mem_rd_addr}, 0);
    t0 = cyc;
    r0 = rd_total;
    rst = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("init_ready_cycle", cyc - t0, 3);
    chk("init_reads", rd_total - r0, 1);
    chk("init_rd_addr", last_rd_addr, 0);
    m_cur   = 0;
    m_depth = 0;
  endtask

  // Monitor: counts reads, pops expectations on response, drives rsp_ready.
  initial begin
    exp_t cur;
    int stall;
    rsp_ready = 1'b0;
    stall = 0;
    forever begin
      @(negedge clk);
      if (mem_rd_en) begin
        rd_total++;
        last_rd_addr = mem_rd_addr;
      end
      if (rst) begin
        exp_q.delete();
        in_rsp    = 0;
        rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        if (!in_rsp) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
            stall = 0;
          end else begin
            cur    = exp_q.pop_front();
            in_rsp = 1;
            chk("rsp_latency", cyc - cur.t_acc, cur.lat);
            chk("rsp_reads", rd_total - cur.rd0, cur.reads);
            stall = (hold_req > 0) ? hold_req : (rand_bp ? int'($urandom_range(0, 3)) : 0);
          end
        end
        if (in_rsp) begin
          chk("rsp_found", rsp_found, cur.found);
          chk("rsp_node_addr", rsp_node_addr, cur.addr);
          chk("rsp_node_id", rsp_node_id, cur.id);
          chk("rsp_depth", rsp_depth, cur.depth);
        end
        if (stall > 0) begin
          stall--;
          rsp_ready = 1'b0;
        end else begin
          rsp_ready = 1'b1;
          in_rsp = 0;
        end
      end else begin
        if (in_rsp) chk("rsp_dropped", 1, 0);
        in_rsp    = 0;
        rsp_ready = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ids [14] = '{5, 7, 9, 21, 23, 25, 11, 0, 31, 32, 33, 34, 4, 60};
    int n;
    logic [ID_W-1:0] rid;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_id = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0]  = mk_node(8'h3C, 1, 2, 0, 0, 0);
    mem[1]  = mk_node(5, 3, 0, 0, 0, 0);
    mem[2]  = mk_node(7, 0, 0, 0, 0, 0);
    mem[3]  = mk_node(9, 6, 0, 0, 0, 1);
    mem[6]  = mk_node(21, 10, 0, 0, 0, 3);
    mem[10] = mk_node(23, 11, 0, 0, 0, 6);
    mem[11] = mk_node(25, 0, 0, 0, 0, 10);
    mem[4]  = mk_node(11, 12, 13, 14, 15, 0);
    mem[5]  = mk_node(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) mem[12 + i] = mk_node(31 + i, 0, 0, 0, 0, 4);

    @(negedge clk);
    do_reset();

    send(2'd0, 8'd7);
    send(2'd2, 8'd0);
    send(2'd0, 8'd5);
    send(2'd0, 8'd9);
    send(2'd1, 8'd0);
    send(2'd1, 8'd0);
    send(2'd1, 8'd0);
    hold_req = 10;
    send(2'd0, 8'd4);
    hold_req = 0;
    send(2'd0, 8'd5);
    send(2'd0, 8'd9);
    send(2'd0, 8'd21);
    send(2'd0, 8'd23);
    send(2'd0, 8'd25);
    send(2'd3, 8'd0);

    mem[0] = mk_node(8'h3C, 1, 2, 4, 5, 0);
    send(2'd2, 8'd0);
    send(2'd0, 8'd4);
    send(2'd0, 8'd0);
    send(2'd0, 8'd11);
    send(2'd0, 8'd34);
    send(2'd2, 8'd0);

    send(2'd0, 8'd5);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_id    = 8'd9;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    do_reset();
    repeat (4) @(negedge clk);
    send(2'd0, 8'd5);

    rand_bp = 1;
    repeat (90) begin
      rid = ($urandom_range(0, 7) == 0) ? ID_W'($urandom_range(0, 255))
                                         : ID_W'(ids[$urandom_range(0, 13)]);
      send(2'($urandom_range(0, 3)), rid);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
